mem_shadow_ctrl: RTL and testbench

//   Shadow-access sequencer for one single-port sram (1-cycle read latency).

---
 rtl/mem_shadow_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_mem_shadow_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_shadow_ctrl.sv
// mem_shadow_ctrl
//   Shadow-access sequencer for a single-port SRAM with 1-cycle read latency.
//   It muxes a functional port and a shadow command engine onto the memory.
//   The engine either dumps a contiguous address range out on a valid/ready
//   stream, or loads a range from one. This lets memory contents be
//   checkpointed and restored while the surrounding design keeps running.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   func_req_i/we/addr/wdata  functional access request
//   func_gnt_o             functional access granted this cycle
//   func_rdata_o           read data straight from the SRAM
//   cmd_valid_i/ready_o    shadow command handshake (ready only while idle)
//   cmd_op_i               0 = dump, 1 = load
//   cmd_base_i, cmd_len_i  first address, word count minus one
//   out_valid_o/ready_i/data_o  dump word stream
//   in_valid_i/ready_o/data_i   load word stream
//   busy_o                 command in progress
//   done_o                 one-cycle pulse when a command completes
//   mem_req_o/we_o/addr_o/wdata_o, mem_rdata_i  SRAM interface
//
// Configuration
//   MEM_SHADOW_STARVE_GUARD_EN  when defined, a shadow access blocked for
//   StarveLimit consecutive cycles takes the following cycle away from the
//   functional port. When undefined, the functional port always wins.

module mem_shadow_ctrl #(
    parameter int Depth       = 64,
    parameter int DataWidth   = 16,
    parameter int AddrWidth   = $clog2(Depth),
    parameter int StarveLimit = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 func_req_i,
    input  logic                 func_we_i,
    input  logic [AddrWidth-1:0] func_addr_i,
    input  logic [DataWidth-1:0] func_wdata_i,
    output logic                 func_gnt_o,
    output logic [DataWidth-1:0] func_rdata_o,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_op_i,
    input  logic [AddrWidth-1:0] cmd_base_i,
    input  logic [AddrWidth-1:0] cmd_len_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        RD_OUT,
        WR_IN,
        WR_REQ,
        DONE
    } state_t;

    state_t               state, state_next;
    logic [AddrWidth-1:0] addr, addr_next;
    logic [AddrWidth-1:0] cnt, cnt_next;
    logic [DataWidth-1:0] data, data_next;

    logic in_req_state;
    logic force_slot;
    logic shadow_go;

    assign in_req_state = (state == RD_REQ) || (state == WR_REQ);

    // The functional port owns the memory unless the starvation guard has
    // reserved this cycle for the shadow engine.
    assign func_gnt_o = func_req_i && !force_slot;
    assign shadow_go  = in_req_state && (!func_req_i || force_slot);

`ifdef MEM_SHADOW_STARVE_GUARD_EN
    localparam int StarveWidth = $clog2(StarveLimit + 1);

    logic [StarveWidth-1:0] starve_cnt;

    assign force_slot = in_req_state && (starve_cnt == StarveWidth'(StarveLimit));

    // Counts consecutive blocked request cycles; any issued shadow access or
    // leaving the request states restarts the count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (!in_req_state || shadow_go) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + StarveWidth'(1);
        end
    end
`else
    logic unused_starve_limit;

    assign force_slot          = 1'b0;
    assign unused_starve_limit = ^StarveLimit;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            cnt   <= cnt_next;
            data  <= data_next;
        end
    end

    // Next-state logic. After each word the range either finishes (count
    // exhausted) or steps to the next address; the address wraps naturally
    // because Depth is a power of two.
    always_comb begin
        state_next = state;
        addr_next  = addr;
        cnt_next   = cnt;
        data_next  = data;
        case (state)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_next  = cmd_base_i;
                    cnt_next   = cmd_len_i;
                    state_next = cmd_op_i ? WR_IN : RD_REQ;
                end
            end
            RD_REQ: begin
                if (shadow_go) begin
                    state_next = RD_CAP;
                end
            end
            RD_CAP: begin
                // Read data is valid exactly one cycle after the request,
                // whoever owns the memory in this cycle.
                data_next  = mem_rdata_i;
                state_next = RD_OUT;
            end
            RD_OUT: begin
                if (out_ready_i) begin
                    if (cnt == '0) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = addr + AddrWidth'(1);
                        cnt_next   = cnt - AddrWidth'(1);
                        state_next = RD_REQ;
                    end
                end
            end
            WR_IN: begin
                if (in_valid_i) begin
                    data_next  = in_data_i;
                    state_next = WR_REQ;
                end
            end
            WR_REQ: begin
                if (shadow_go) begin
                    if (cnt == '0) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = addr + AddrWidth'(1);
                        cnt_next   = cnt - AddrWidth'(1);
                        state_next = WR_IN;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory port mux: functional grant first, then a shadow access.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (func_gnt_o) begin
            mem_req_o   = 1'b1;
            mem_we_o    = func_we_i;
            mem_addr_o  = func_addr_i;
            mem_wdata_o = func_wdata_i;
        end else if (shadow_go) begin
            mem_req_o   = 1'b1;
            mem_we_o    = (state == WR_REQ);
            mem_addr_o  = addr;
            mem_wdata_o = data;
        end
    end

    assign func_rdata_o = mem_rdata_i;
    assign cmd_ready_o  = (state == IDLE);
    assign busy_o       = (state != IDLE) && (state != DONE);
    assign done_o       = (state == DONE);
    assign out_valid_o  = (state == RD_OUT);
    assign out_data_o   = data;
    assign in_ready_o   = (state == WR_IN);

endmodule

// File: tb/tb_mem_shadow_ctrl.sv
// Self-checking bench for mem_shadow_ctrl with a behavioural 1-cycle SRAM.
// Expected dump words are queued when a dump command is driven and popped
// whenever the DUT completes an output handshake.

module tb_mem_shadow_ctrl;

    localparam int Depth = 64;
    localparam int DW    = 16;
    localparam int AW    = 6;
`ifdef MEM_SHADOW_STARVE_GUARD_EN
    localparam bit GuardOn = 1'b1;
`else
    localparam bit GuardOn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          func_req = 1'b0;
    logic          func_we = 1'b0;
    logic [AW-1:0] func_addr = '0;
    logic [DW-1:0] func_wdata = '0;
    logic          func_gnt;
    logic [DW-1:0] func_rdata;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          busy;
    logic          done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic          preload = 1'b0;
    logic [DW-1:0] sram [Depth];
    logic [DW-1:0] model [Depth];
    logic [DW-1:0] sbq [$];

    int compared = 0;
    int mismatched = 0;

    mem_shadow_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .func_req_i   (func_req),
        .func_we_i    (func_we),
        .func_addr_i  (func_addr),
        .func_wdata_i (func_wdata),
        .func_gnt_o   (func_gnt),
        .func_rdata_o (func_rdata),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_base_i   (cmd_base),
        .cmd_len_i    (cmd_len),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .busy_o       (busy),
        .done_o       (done),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pattern(input int i);
        return 16'h5A00 ^ (16'(i) * 16'h0103);
    endfunction

    // Behavioural single-port SRAM with one cycle of read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < Depth; i++) sram[i] <= pattern(i);
        end else if (mem_req) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard: every completed dump handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checkOutput("dump_extra_word", {31'b0, out_valid}, 32'd0);
            end else begin
                checkOutput("dump_word", out_data, sbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one accepting edge; dump expectations are queued here.
    task automatic applyStimulus(input logic op, input int base, input int len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_base  = AW'(base);
        cmd_len   = AW'(len);
        if (!op) begin
            for (int i = 0; i <= len; i++) sbq.push_back(model[(base + i) % Depth]);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = done;
        end
        checkOutput(tag, {31'b0, seen}, 32'd1);
    endtask

    task automatic readWord(input string tag, input int addr);
        func_req  = 1'b1;
        func_we   = 1'b0;
        func_addr = AW'(addr);
        tick();
        func_req = 1'b0;
        checkOutput(tag, func_rdata, model[addr]);
    endtask

    initial begin
        bit saw_done;
        bit got;

        for (int i = 0; i < Depth; i++) model[i] = pattern(i);

        // Reset and preload
        preload = 1'b1;
        tick();
        tick();
        preload = 1'b0;
        checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_out_data", {16'b0, out_data}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Functional write passes straight through to the memory
        func_req   = 1'b1;
        func_we    = 1'b1;
        func_addr  = 6'd7;
        func_wdata = 16'h1234;
        #1;
        checkOutput("func_gnt", {31'b0, func_gnt}, 32'd1);
        checkOutput("func_mem_we", {31'b0, mem_we}, 32'd1);
        checkOutput("func_mem_addr", {26'b0, mem_addr}, 32'd7);
        checkOutput("func_mem_wdata", {16'b0, mem_wdata}, 32'h1234);
        tick();
        func_req = 1'b0;
        func_we  = 1'b0;
        model[7] = 16'h1234;

        // Dump base=4 len=2 with done in cycle 10 after the accept cycle
        applyStimulus(1'b0, 4, 2);
        checkOutput("dump_busy", {31'b0, busy}, 32'd1);
        checkOutput("dump_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        checkOutput("dump_early_done", {31'b0, saw_done}, 32'd0);
        tick();
        checkOutput("dump_done_cycle10", {31'b0, done}, 32'd1);
        checkOutput("dump_done_busy", {31'b0, busy}, 32'd0);
        tick();
        checkOutput("dump_back_idle", {31'b0, cmd_ready}, 32'd1);
        checkOutput("dump_queue_empty", sbq.size(), 32'd0);

        // Load base=62 len=3 wrapping through the top of memory
        applyStimulus(1'b1, 62, 3);
        for (int w = 0; w < 4; w++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                if (in_ready) got = 1'b1;
                else tick();
            end
            checkOutput("load_in_ready", {31'b0, got}, 32'd1);
            in_valid = 1'b1;
            in_data  = 16'h00A1 + 16'(w);
            model[(62 + w) % Depth] = in_data;
            tick();
            in_valid = 1'b0;
        end
        waitDone("load_done", 10);
        tick();
        readWord("load_rb62", 62);
        readWord("load_rb63", 63);
        readWord("load_rb0", 0);
        readWord("load_rb1", 1);
        readWord("load_rb2_untouched", 2);

        // Dump across the wrap point
        applyStimulus(1'b0, 60, 5);
        waitDone("wrap_dump_done", 40);
        tick();
        checkOutput("wrap_queue_empty", sbq.size(), 32'd0);

        // Functional port held for 20 cycles during a dump
        func_req  = 1'b1;
        func_we   = 1'b0;
        func_addr = 6'd0;
        applyStimulus(1'b0, 10, 1);
        for (int c = 1; c <= 20; c++) begin
            bit forced;
            forced = GuardOn && (c == 9 || c == 20);
            checkOutput($sformatf("stall_gnt_c%0d", c), {31'b0, func_gnt}, {31'b0, !forced});
            checkOutput($sformatf("stall_shadow_c%0d", c), {31'b0, mem_req && !func_gnt},
                        {31'b0, forced});
            tick();
        end
        func_req = 1'b0;
        waitDone("stall_done", 30);
        tick();
        checkOutput("stall_queue_empty", sbq.size(), 32'd0);

        // Output backpressure for 5 cycles in RD_OUT
        out_ready = 1'b0;
        applyStimulus(1'b0, 20, 1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else tick();
        end
        checkOutput("bp_reach_out", {31'b0, got}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid_held", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_data_stable", {16'b0, out_data}, {16'b0, model[20]});
            checkOutput("bp_no_mem_req", {31'b0, mem_req}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        waitDone("bp_done", 20);
        tick();
        checkOutput("bp_queue_empty", sbq.size(), 32'd0);

        // Reset pulsed while a dump word waits in RD_OUT
        out_ready = 1'b0;
        applyStimulus(1'b0, 30, 3);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else tick();
        end
        checkOutput("rstmid_reach_out", {31'b0, got}, 32'd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        sbq.delete();
        tick();
        checkOutput("rstmid_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstmid_busy", {31'b0, busy}, 32'd0);
        checkOutput("rstmid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        saw_done = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            saw_done = saw_done | done;
            got = got | mem_req;
            tick();
        end
        checkOutput("rstmid_no_done", {31'b0, saw_done}, 32'd0);
        checkOutput("rstmid_no_mem_req", {31'b0, got}, 32'd0);
        out_ready = 1'b1;
        applyStimulus(1'b0, 40, 1);
        waitDone("rstmid_new_done", 20);
        tick();
        checkOutput("rstmid_queue_empty", sbq.size(), 32'd0);

        // Command presented while busy is ignored
        applyStimulus(1'b0, 50, 2);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_base  = 6'd5;
        cmd_len   = 6'd0;
        #1;
        checkOutput("ignore_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        tick();
        cmd_valid = 1'b0;
        waitDone("ignore_done", 30);
        tick();
        checkOutput("ignore_queue_empty", sbq.size(), 32'd0);
        checkOutput("ignore_idle_after", {31'b0, busy}, 32'd0);
        tick();
        tick();

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
